dm_dmi_slave: RTL and testbench
===============================

Name: dm_dmi_slave

Overview:
Debug Module front end sitting directly downstream of the JTAG DTM. It accepts DMI requests (addr/data/op), decodes them against a small DM register file, and returns DMI responses. The registers are data0, dmcontrol, dmstatus, hartinfo, abstractcs and command. It drives halt/resume/ndmreset to the hart and runs abstract register-access commands over a req/ack handshake to the core.

Parameters:
- DBUS_ADDR_WIDTH, 7: DMI address bits.
- DBUS_DATA_WIDTH, 32: DMI data bits.
- DBUS_OP_WIDTH, 2: DMI op bits.
- ABS_TIMEOUT, 255: cycles to wait for core_ack before cmderr=exception(3).

Ports:
- TCK  in  1  clock; same clock as the DTM, no CDC inside this block.
- TRST  in  1  synchronous active-high reset.
- dtm_valid  in  1  request valid.
- dmi_ready  out  1  ready to accept a request.
- dtm_bits  in  41  {addr[40:34], data[33:2], op[1:0]}.
- dmi_valid  out  1  response valid.
- dtm_ready  in  1  DTM accepts the response.
- dmi_bits  out  34  {data[33:2], resp[1:0]}.
- halt_req  out  1  dmcontrol.haltreq.
- resume_req  out  1  resume pulse.
- ndmreset  out  1  dmcontrol.ndmreset.
- hart_halted  in  1  hart is halted.
- hart_resumeack  in  1  one-cycle resume acknowledge.
- abs_req  out  1  abstract register access request.
- abs_write  out  1  1 = write GPR/CSR.
- abs_regno  out  16  register number.
- abs_wdata  out  32  write data (data0).
- abs_ack  in  1  one-cycle access completion.
- abs_rdata  in  32  read data, valid with abs_ack.

Behaviour:
- Clock and reset:
  - One clock, TCK. Reset is synchronous and active-high on TRST.
  - Reset values: all outputs 0 except dmi_ready=1. All registers 0. dmactive=0.
- DMI FSM states: D_IDLE, D_RESP.
  - D_IDLE: dmi_ready=1. When dtm_valid=1, the request is decoded and executed in that same cycle. Move to D_RESP with dmi_bits registered, so latency is 1 cycle.
  - D_RESP: dmi_valid=1, dmi_ready=0, dmi_bits held stable. When dtm_ready=1, return to D_IDLE. Back-to-back requests are therefore accepted at most every 2 cycles.
- Op encoding:
  - 0 nop: response data 0, resp 0.
  - 1 read, 2 write: register access.
  - 3 reserved: resp 2 (failed), no side effect.
- Response codes: resp 0 = success, 3 = busy.
  - Busy: access to data0 or command while abstractcs.busy=1. The access has no effect. Sets cmderr=1 only if cmderr==0.
- Address map; unmapped addresses read 0, writes are ignored, resp 0:
  - 0x04 data0: RW.
  - 0x10 dmcontrol: haltreq[31], resumereq[30] (write-1 pulse), ndmreset[1], dmactive[0].
    - While dmactive=0, every other field and register write is ignored. Writing dmactive=0 clears all DM state (same as reset).
  - 0x11 dmstatus: RO.
    - allhalted/anyhalted = hart_halted.
    - allrunning/anyrunning = !hart_halted.
    - allresumeack/anyresumeack = sticky, set by hart_resumeack, cleared by a resumereq write.
    - authenticated=1; version=2.
  - 0x12 hartinfo: RO 0.
  - 0x16 abstractcs:
    - progbufsize[28:24], busy[12] RO, datacount[3:0]=1.
    - cmderr[10:8] is W1C.
  - 0x17 command: WO, reads 0.
    - cmdtype[31:24] must be 0 (access register), otherwise cmderr=2.
    - aarsize must be 2, otherwise cmderr=2.
    - Hart not halted gives cmderr=4.
    - Any cmderr!=0 blocks new commands: the write is ignored, no state change.
- resume_req: one-cycle pulse on a resumereq=1 write, only if hart_halted=1. If haltreq and resumereq are written at the same time, haltreq wins and there is no resume pulse.
- Abstract FSM states: A_IDLE, A_REQ, A_WAIT.
  - Valid command with transfer=1: go to A_REQ, busy=1, abs_req=1.
  - A_REQ moves to A_WAIT on the next cycle; abs_req stays high until abs_ack.
  - On abs_ack:
    - Read (write=0): data0 <= abs_rdata.
    - Then busy=0, back to A_IDLE.
  - Timeout counter reaches ABS_TIMEOUT: cmderr=3, busy=0, A_IDLE.
  - transfer=0: command completes immediately, no abs_req.
- Reset mid-command: everything returns to reset state and abs_req drops in the same cycle. A late abs_ack is ignored.

Optional Feature:
- DM_PROGBUF_EN defined:
  - progbuf0/progbuf1 RW at 0x20/0x21; progbufsize=2.
  - postexec[18]=1 after a successful transfer sets cmderr=2; execution is unsupported, registers only.
  - progbuf access while busy returns resp 3.
- Undefined: 0x20/0x21 read 0, progbufsize=0, postexec is ignored.

Decomposition:
- Shared package dbg_defines:
  - DBUS_* widths; DMI op/resp codes.
  - DM register addresses; cmderr codes.
  - Abstract FSM state encodings.
- One sub-module, dm_abs_cmd: abstract FSM, timeout counter, abs_* interface, busy/cmderr update.

Test Plan:
- Reset then read 0x11 -> dmi_bits data=0x00000C82 (version 2, authenticated, allrunning/anyrunning with hart_halted=0), resp 0, dmi_valid 1 cycle after accept.
- Write dmcontrol 0x80000001 -> halt_req=1. Set hart_halted=1. Read dmstatus -> allhalted bit9=1.
- Halted: write data0=0xDEADBEEF, write command 0x00230008 -> abs_req=1, abs_write=1, abs_regno=0x0008, abs_wdata=0xDEADBEEF. Read abstractcs before ack -> busy=1. abs_ack -> busy=0.
- During busy, write data0 -> resp 3, cmderr=1. Write abstractcs 0x00000700 -> cmderr=0.
- Command read of regno 0x1000 with abs_ack never asserted -> after 255 cycles cmderr=3, busy=0.
- Hart running, write command 0x00220300 -> cmderr=4, no abs_req. With dtm_ready held low for 5 cycles -> dmi_valid and dmi_bits stable and dmi_ready=0 throughout.

Source files
------------

// File: rtl/dbg_defines.sv
// dbg_defines: shared DMI widths, op/resp codes, DM register map, cmderr codes and FSM encodings
package dbg_defines;
  localparam int DBUS_ADDR_WIDTH = 7;
  localparam int DBUS_DATA_WIDTH = 32;
  localparam int DBUS_OP_WIDTH = 2;
  localparam int DTM_REQ_WIDTH = DBUS_ADDR_WIDTH + DBUS_DATA_WIDTH + DBUS_OP_WIDTH;
  localparam int DMI_RESP_WIDTH = DBUS_DATA_WIDTH + 2;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;
  localparam logic [1:0] RESP_OK = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;
  localparam logic [6:0] ADDR_DATA0 = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO = 7'h12;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND = 7'h17;
  localparam logic [6:0] ADDR_PROGBUF0 = 7'h20;
  localparam logic [6:0] ADDR_PROGBUF1 = 7'h21;
  localparam logic [2:0] CMDERR_NONE = 3'd0;
  localparam logic [2:0] CMDERR_BUSY = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  typedef enum logic {D_IDLE, D_RESP} dmi_state_e;
  typedef enum logic [1:0] {A_IDLE, A_REQ, A_WAIT} abs_state_e;
endpackage

// File: rtl/dm_dmi_slave_if.sv
// dm_dmi_slave_if: DMI request/response handshake between the DTM (master) and the DM (slave)
interface dm_dmi_slave_if;
  import dbg_defines::*;
  logic dtm_valid;
  logic dmi_ready;
  logic [DTM_REQ_WIDTH-1:0] dtm_bits;
  logic dmi_valid;
  logic dtm_ready;
  logic [DMI_RESP_WIDTH-1:0] dmi_bits;
  modport master (output dtm_valid, dtm_bits, dtm_ready, input dmi_ready, dmi_valid, dmi_bits);
  modport slave (input dtm_valid, dtm_bits, dtm_ready, output dmi_ready, dmi_valid, dmi_bits);
endinterface

// File: rtl/dm_abs_cmd.sv
// dm_abs_cmd: abstract register-access sequencer with timeout and cmderr; DM_PROGBUF_EN enables postexec reporting
module dm_abs_cmd
  import dbg_defines::*;
#(
  parameter int ABS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        cmd_wr,
  input  logic [31:0] cmd,
  input  logic        hart_halted,
  input  logic [2:0]  w1c,
  input  logic        busy_err,
  input  logic        abs_ack,
  output logic        busy,
  output logic [2:0]  cmderr,
  output logic        abs_write,
  output logic [15:0] abs_regno,
  output logic        ld_data0
);
  localparam int CW = $clog2(ABS_TIMEOUT + 1);
  abs_state_e state;
  logic [CW-1:0] cnt;
  logic post, post_q, bad, unused_cmd;
`ifdef DM_PROGBUF_EN
  assign post = cmd[18];
`else
  assign post = 1'b0;
`endif
  assign unused_cmd = ^{cmd[23], cmd[19:18]};
  assign busy = state != A_IDLE;
  assign ld_data0 = busy && abs_ack && !abs_write;
  assign bad = cmd[31:24] != 8'd0 || cmd[22:20] != 3'd2;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= A_IDLE;
      cnt <= '0;
      post_q <= 1'b0;
      cmderr <= CMDERR_NONE;
      abs_write <= 1'b0;
      abs_regno <= '0;
    end else begin
      if (busy_err && cmderr == CMDERR_NONE) cmderr <= CMDERR_BUSY;
      else if (|w1c) cmderr <= cmderr & ~w1c;
      case (state)
        A_IDLE: if (cmd_wr && cmderr == CMDERR_NONE) begin
          if (bad) cmderr <= CMDERR_NOTSUP;
          else if (!hart_halted) cmderr <= CMDERR_HALTRESUME;
          else if (cmd[17]) begin
            state <= A_REQ;
            cnt <= '0;
            post_q <= post;
            abs_write <= cmd[16];
            abs_regno <= cmd[15:0];
          end else if (post) cmderr <= CMDERR_NOTSUP;
        end
        default: if (abs_ack) begin
          state <= A_IDLE;
          if (post_q) cmderr <= CMDERR_NOTSUP;
        end else if (cnt == CW'(ABS_TIMEOUT - 1)) begin
          state <= A_IDLE;
          cmderr <= CMDERR_EXCEPTION;
        end else begin
          state <= A_WAIT;
          cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/dm_dmi_slave.sv
// dm_dmi_slave: RISC-V Debug Module front end behind the DTM; DM_PROGBUF_EN adds progbuf0/progbuf1
module dm_dmi_slave
  import dbg_defines::*;
#(
  parameter int ABS_TIMEOUT = 255
) (
  input  logic          TCK,
  input  logic          TRST,
  dm_dmi_slave_if.slave dmi,
  output logic          halt_req,
  output logic          resume_req,
  output logic          ndmreset,
  input  logic          hart_halted,
  input  logic          hart_resumeack,
  output logic          abs_req,
  output logic          abs_write,
  output logic [15:0]   abs_regno,
  output logic [31:0]   abs_wdata,
  input  logic          abs_ack,
  input  logic [31:0]   abs_rdata
);
  dmi_state_e state;
  logic [DBUS_ADDR_WIDTH-1:0] addr;
  logic [DBUS_DATA_WIDTH-1:0] wdata, rdata, rsp_data, data0;
  logic [DBUS_OP_WIDTH-1:0] op;
  logic [1:0] resp;
  logic [2:0] cmderr;
  logic [4:0] progbufsize;
  logic dmactive, resumeack, busy, ld_data0;
  logic accept, busy_reg, busy_acc, wr, dm_clear, res_wr, res_pulse;
  assign {addr, wdata, op} = dmi.dtm_bits;
  assign accept = state == D_IDLE && dmi.dtm_valid;
`ifdef DM_PROGBUF_EN
  logic [31:0] progbuf0, progbuf1;
  assign progbufsize = 5'd2;
  assign busy_reg = addr inside {ADDR_DATA0, ADDR_COMMAND, ADDR_PROGBUF0, ADDR_PROGBUF1};
`else
  assign progbufsize = 5'd0;
  assign busy_reg = addr inside {ADDR_DATA0, ADDR_COMMAND};
`endif
  assign busy_acc = busy && busy_reg && (op == OP_READ || op == OP_WRITE);
  assign wr = accept && op == OP_WRITE && !busy_acc;
  assign dm_clear = wr && addr == ADDR_DMCONTROL && !wdata[0];
  assign res_wr = wr && addr == ADDR_DMCONTROL && wdata[0] && wdata[30];
  // haltreq in the same write suppresses the resume pulse
  assign res_pulse = res_wr && !wdata[31] && hart_halted;
  assign resp = op == OP_RSVD ? RESP_FAIL : busy_acc ? RESP_BUSY : RESP_OK;
  assign rsp_data = (op == OP_READ && !busy_acc) ? rdata : '0;
  assign abs_req = busy && !TRST;
  assign abs_wdata = data0;
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA0: rdata = data0;
      ADDR_DMCONTROL: rdata = {halt_req, 29'b0, ndmreset, dmactive};
      ADDR_DMSTATUS: rdata = {14'b0, {2{resumeack}}, 4'b0, {2{!hart_halted}}, {2{hart_halted}}, 1'b1, 3'b0, 4'd2};
      ADDR_ABSTRACTCS: rdata = {3'b0, progbufsize, 11'b0, busy, 1'b0, cmderr, 4'b0, 4'd1};
`ifdef DM_PROGBUF_EN
      ADDR_PROGBUF0: rdata = progbuf0;
      ADDR_PROGBUF1: rdata = progbuf1;
`endif
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state <= D_IDLE;
      dmi.dmi_ready <= 1'b1;
      dmi.dmi_valid <= 1'b0;
      dmi.dmi_bits <= '0;
    end else if (state == D_IDLE) begin
      if (dmi.dtm_valid) begin
        state <= D_RESP;
        dmi.dmi_ready <= 1'b0;
        dmi.dmi_valid <= 1'b1;
        dmi.dmi_bits <= {rsp_data, resp};
      end
    end else if (dmi.dtm_ready) begin
      state <= D_IDLE;
      dmi.dmi_ready <= 1'b1;
      dmi.dmi_valid <= 1'b0;
    end
  end
  always_ff @(posedge TCK) begin
    if (TRST || dm_clear) begin
      data0 <= '0;
      halt_req <= 1'b0;
      ndmreset <= 1'b0;
      dmactive <= 1'b0;
      resumeack <= 1'b0;
      resume_req <= 1'b0;
`ifdef DM_PROGBUF_EN
      progbuf0 <= '0;
      progbuf1 <= '0;
`endif
    end else begin
      resume_req <= res_pulse;
      resumeack <= hart_resumeack || (resumeack && !res_wr);
      if (ld_data0) data0 <= abs_rdata;
      if (wr && addr == ADDR_DMCONTROL) {halt_req, ndmreset, dmactive} <= {wdata[31], wdata[1], 1'b1};
      if (wr && dmactive && addr == ADDR_DATA0) data0 <= wdata;
`ifdef DM_PROGBUF_EN
      if (wr && dmactive && addr == ADDR_PROGBUF0) progbuf0 <= wdata;
      if (wr && dmactive && addr == ADDR_PROGBUF1) progbuf1 <= wdata;
`endif
    end
  end
  dm_abs_cmd #(.ABS_TIMEOUT(ABS_TIMEOUT)) u_abs (
    .clk(TCK),
    .rst(TRST),
    .clr(dm_clear),
    .cmd_wr(wr && dmactive && addr == ADDR_COMMAND),
    .cmd(wdata),
    .hart_halted(hart_halted),
    .w1c((wr && dmactive && addr == ADDR_ABSTRACTCS) ? wdata[10:8] : 3'b0),
    .busy_err(accept && busy_acc),
    .abs_ack(abs_ack),
    .busy(busy),
    .cmderr(cmderr),
    .abs_write(abs_write),
    .abs_regno(abs_regno),
    .ld_data0(ld_data0)
  );
endmodule

// File: tb/tb_dm_dmi_slave.sv
// tb_dm_dmi_slave: directed self-checking bench for dm_dmi_slave
module tb_dm_dmi_slave;
  logic TCK = 1'b0, TRST = 1'b1;
  logic hart_halted = 1'b0, hart_resumeack = 1'b0, abs_ack = 1'b0;
  logic [31:0] abs_rdata = '0;
  logic halt_req, resume_req, ndmreset, abs_req, abs_write;
  logic [15:0] abs_regno;
  logic [31:0] abs_wdata;
  int n_chk = 0, n_pass = 0, n_res = 0;
  dm_dmi_slave_if dmi();
  dm_dmi_slave dut (
    .TCK(TCK),
    .TRST(TRST),
    .dmi(dmi),
    .halt_req(halt_req),
    .resume_req(resume_req),
    .ndmreset(ndmreset),
    .hart_halted(hart_halted),
    .hart_resumeack(hart_resumeack),
    .abs_req(abs_req),
    .abs_write(abs_write),
    .abs_regno(abs_regno),
    .abs_wdata(abs_wdata),
    .abs_ack(abs_ack),
    .abs_rdata(abs_rdata)
  );
  always #5 TCK = ~TCK;
  always @(negedge TCK) if (resume_req) n_res++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic dmi_txn(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o,
                         output logic [31:0] rd, output logic [1:0] rs);
    for (int t = 0; t < 20 && !dmi.dmi_ready; t++) begin
      @(posedge TCK); #1;
    end
    dmi.dtm_valid = 1'b1;
    dmi.dtm_bits = {a, d, o};
    @(posedge TCK); #1;
    dmi.dtm_valid = 1'b0;
    check("rsp_valid", dmi.dmi_valid, 1);
    {rd, rs} = dmi.dmi_bits;
    @(posedge TCK); #1;
  endtask
  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    dmi_txn(a, 32'h0, 2'd1, d, r);
    check(tag, {d, r}, {exp, 2'd0});
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] x;
    logic [1:0] r;
    dmi_txn(a, d, 2'd2, x, r);
    check("wr_resp", r, 0);
  endtask
  task automatic abs_pulse(input logic [31:0] d);
    abs_rdata = d;
    abs_ack = 1'b1;
    @(posedge TCK); #1;
    abs_ack = 1'b0;
  endtask
  initial begin
    logic [31:0] rd;
    logic [1:0] rs;
    int n, r0;
    dmi.dtm_valid = 1'b0;
    dmi.dtm_bits = '0;
    dmi.dtm_ready = 1'b1;
    repeat (3) @(posedge TCK);
    #1;
    check("rst_ctl", {dmi.dmi_ready, dmi.dmi_valid, halt_req, resume_req, ndmreset, abs_req, abs_write}, 7'b1000000);
    check("rst_bits", dmi.dmi_bits, 0);
    check("rst_abs", {abs_regno, abs_wdata}, 0);
    TRST = 1'b0;
    rd_chk("dmstatus_run", 7'h11, 32'h00000C82);
    wr(7'h04, 32'h12345678);
    rd_chk("data0_inactive", 7'h04, 32'h0);
    wr(7'h10, 32'h80000001);
    check("halt_req", halt_req, 1);
    rd_chk("dmcontrol", 7'h10, 32'h80000001);
    hart_halted = 1'b1;
    rd_chk("dmstatus_halt", 7'h11, 32'h00000382);
    wr(7'h10, 32'h00000001);
    wr(7'h04, 32'hDEADBEEF);
    wr(7'h17, 32'h00230008);
    check("abs_wr_req", {abs_req, abs_write, abs_regno}, {2'b11, 16'h0008});
    check("abs_wdata", abs_wdata, 32'hDEADBEEF);
    rd_chk("acs_busy", 7'h16, 32'h00001001);
    dmi_txn(7'h04, 32'h11111111, 2'd2, rd, rs);
    check("busy_wr_resp", rs, 3);
    dmi_txn(7'h04, 32'h0, 2'd1, rd, rs);
    check("busy_rd_resp", {rd, rs}, {32'h0, 2'd3});
    rd_chk("acs_cmderr1", 7'h16, 32'h00001101);
    abs_pulse(32'h0);
    check("abs_req_done", abs_req, 0);
    rd_chk("acs_idle_err", 7'h16, 32'h00000101);
    rd_chk("data0_kept", 7'h04, 32'hDEADBEEF);
    wr(7'h16, 32'h00000700);
    rd_chk("acs_clear", 7'h16, 32'h00000001);
    wr(7'h17, 32'h00221000);
    check("abs_rd_req", {abs_req, abs_write, abs_regno}, {2'b10, 16'h1000});
    n = 2;
    for (int i = 0; i < 400 && abs_req; i++) begin
      @(posedge TCK); #1;
      if (abs_req) n++;
    end
    check("timeout_cycles", n, 255);
    rd_chk("acs_timeout", 7'h16, 32'h00000301);
    abs_pulse(32'h00000BAD);
    rd_chk("late_ack", 7'h04, 32'hDEADBEEF);
    wr(7'h17, 32'h00230008);
    check("cmd_blocked", abs_req, 0);
    wr(7'h16, 32'h00000700);
    wr(7'h17, 32'h00221000);
    abs_pulse(32'hCAFEF00D);
    rd_chk("data0_rdata", 7'h04, 32'hCAFEF00D);
    wr(7'h17, 32'h01230008);
    rd_chk("acs_cmdtype", 7'h16, 32'h00000201);
    wr(7'h16, 32'h00000700);
    wr(7'h17, 32'h00330008);
    rd_chk("acs_aarsize", 7'h16, 32'h00000201);
    wr(7'h16, 32'h00000700);
    hart_halted = 1'b0;
    wr(7'h17, 32'h00220300);
    check("running_no_req", abs_req, 0);
    dmi.dtm_ready = 1'b0;
    dmi.dtm_valid = 1'b1;
    dmi.dtm_bits = {7'h16, 32'h0, 2'd1};
    @(posedge TCK); #1;
    dmi.dtm_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall", {dmi.dmi_valid, dmi.dmi_ready, dmi.dmi_bits}, {2'b10, 32'h00000401, 2'd0});
      @(posedge TCK); #1;
    end
    dmi.dtm_ready = 1'b1;
    @(posedge TCK); #1;
    check("stall_release", {dmi.dmi_valid, dmi.dmi_ready}, 2'b01);
    wr(7'h16, 32'h00000700);
    hart_halted = 1'b1;
    r0 = n_res;
    wr(7'h10, 32'h40000001);
    check("resume_pulse", n_res - r0, 1);
    wr(7'h10, 32'hC0000001);
    check("halt_wins_pulse", n_res - r0, 1);
    check("halt_wins_req", halt_req, 1);
    hart_resumeack = 1'b1;
    @(posedge TCK); #1;
    hart_resumeack = 1'b0;
    rd_chk("resumeack", 7'h11, 32'h00030382);
    wr(7'h10, 32'h40000001);
    check("resume_pulse2", n_res - r0, 2);
    rd_chk("resumeack_clr", 7'h11, 32'h00000382);
    wr(7'h10, 32'h00000003);
    check("ndmreset", {halt_req, ndmreset}, 2'b01);
    wr(7'h10, 32'h00000000);
    check("dm_clear", {halt_req, ndmreset}, 2'b00);
    rd_chk("data0_cleared", 7'h04, 32'h0);
    rd_chk("dmcontrol_cleared", 7'h10, 32'h0);
    wr(7'h10, 32'h00000001);
    wr(7'h04, 32'h00000055);
    dmi_txn(7'h04, 32'hFFFFFFFF, 2'd3, rd, rs);
    check("op_rsvd", {rd, rs}, {32'h0, 2'd2});
    rd_chk("op_rsvd_noeffect", 7'h04, 32'h00000055);
    dmi_txn(7'h11, 32'h0, 2'd0, rd, rs);
    check("op_nop", {rd, rs}, 0);
    rd_chk("unmapped", 7'h05, 32'h0);
    rd_chk("hartinfo", 7'h12, 32'h0);
    rd_chk("cmd_rd", 7'h17, 32'h0);
    rd_chk("progbuf0", 7'h20, 32'h0);
    wr(7'h17, 32'h00230008);
    check("pre_rst_req", abs_req, 1);
    TRST = 1'b1;
    #1;
    check("rst_drop", abs_req, 0);
    @(posedge TCK); #1;
    TRST = 1'b0;
    abs_pulse(32'h0BADBAD0);
    check("post_rst", {abs_req, halt_req, ndmreset, dmi.dmi_ready}, 4'b0001);
    rd_chk("acs_post_rst", 7'h16, 32'h00000001);
    rd_chk("data0_post_rst", 7'h04, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
